// File: rtl/branch_pc_unit.sv
// Program counter register with beq/bne/j resolution from the ALU ZERO flag.
// Issues a one-cycle FLUSH after each taken transfer and holds state while BUSYWAIT is asserted.
module branch_pc_unit #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ZERO,
    input  logic                    BRANCH,
    input  logic                    BRANCH_NE,
    input  logic                    JUMP,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    input  logic                    BUSYWAIT,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     PC_PLUS4,
    output logic                    TAKEN,
    output logic                    FLUSH,
    output logic                    CTRL_ERR,
    output logic [CNT_WIDTH-1:0]    TAKEN_CNT
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH_ST = 2'd1,
        STALL    = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0]  WORD_BYTES = PC_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                state;
    logic [PC_WIDTH-1:0]   offset_bytes;
    logic [PC_WIDTH-1:0]   target;
    logic                  take;
    logic                  ctrl_conflict;

    assign PC_PLUS4 = PC + WORD_BYTES;

    // Word offset sign-extended and scaled to bytes; the sum wraps modulo 2^PC_WIDTH.
    assign offset_bytes = {{(PC_WIDTH-OFFSET_WIDTH-2){OFFSET[OFFSET_WIDTH-1]}}, OFFSET, 2'b00};
    assign target       = PC_PLUS4 + offset_bytes;

    assign take          = JUMP | (BRANCH & ZERO & ~BRANCH_NE) | (BRANCH_NE & ~ZERO & ~BRANCH);
    assign ctrl_conflict = BRANCH & BRANCH_NE & ~JUMP;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= RUN;
            PC        <= '0;
            TAKEN     <= 1'b0;
            FLUSH     <= 1'b0;
            CTRL_ERR  <= 1'b0;
            TAKEN_CNT <= '0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (BUSYWAIT) begin
                        state <= STALL;
                    end else begin
                        CTRL_ERR <= ctrl_conflict;
                        if (take) begin
                            PC        <= target;
                            TAKEN     <= 1'b1;
                            FLUSH     <= 1'b1;
                            TAKEN_CNT <= TAKEN_CNT + CNT_ONE;
                            state     <= FLUSH_ST;
                        end else begin
                            PC    <= PC_PLUS4;
                            TAKEN <= 1'b0;
                            FLUSH <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                FLUSH_ST: begin
                    // Shadow instruction: controls are ignored, FLUSH stays high while stalled.
                    if (!BUSYWAIT) begin
                        PC    <= PC_PLUS4;
                        TAKEN <= 1'b0;
                        FLUSH <= 1'b0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
